// File: rtl/mix_columns.sv
`default_nettype none
// ============================================================================
//  Module      : mix_columns
//  Description : AES MixColumns round stage. The 128-bit state is treated as
//                four independent 4-byte columns. Each column is multiplied by
//                the fixed AES matrix over GF(2^8) (x^8+x^4+x^3+x+1). The
//                result is registered, so latency is one cycle and the valid
//                flag follows the input valid.
//  Optional    : `define INV_MIX_EN adds the inv port and InvMixColumns logic
//                for the decryption datapath.
//  Ports       : clk       - rising-edge clock
//                reset     - synchronous active-high reset
//                in_valid  - in carries a state this cycle
//                in[127:0] - state, byte i = in[8i+7:8i], column c = bytes
//                            4c..4c+3, byte 4c is row 0
//                inv       - (INV_MIX_EN only) 1 selects InvMixColumns
//                out_valid - out holds a newly computed state
//                out[127:0]- transformed state, same packing as in
//  Revision    : 1.0  initial release
// ============================================================================
module mix_columns (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [127:0] in,
`ifdef INV_MIX_EN
    input  logic         inv,
`endif
    output logic         out_valid,
    output logic [127:0] out
);

    // Multiply by x in GF(2^8): shift left and reduce when bit 7 falls out.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    logic [127:0] w_result;
    logic [127:0] r_out;
    logic         r_out_valid;

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        logic [7:0] w_x2_0, w_x2_1, w_x2_2, w_x2_3;
        logic [31:0] w_fwd;

        assign w_a0 = in[32*c +  0 +: 8];
        assign w_a1 = in[32*c +  8 +: 8];
        assign w_a2 = in[32*c + 16 +: 8];
        assign w_a3 = in[32*c + 24 +: 8];

        assign w_x2_0 = xtime(w_a0);
        assign w_x2_1 = xtime(w_a1);
        assign w_x2_2 = xtime(w_a2);
        assign w_x2_3 = xtime(w_a3);

        // 3*x is 2*x ^ x, so each row folds the "3" term into an extra x.
        assign w_fwd[ 7: 0] = w_x2_0 ^ (w_x2_1 ^ w_a1) ^ w_a2 ^ w_a3;
        assign w_fwd[15: 8] = w_a0 ^ w_x2_1 ^ (w_x2_2 ^ w_a2) ^ w_a3;
        assign w_fwd[23:16] = w_a0 ^ w_a1 ^ w_x2_2 ^ (w_x2_3 ^ w_a3);
        assign w_fwd[31:24] = (w_x2_0 ^ w_a0) ^ w_a1 ^ w_a2 ^ w_x2_3;

`ifdef INV_MIX_EN
        logic [7:0] w_x4_0, w_x4_1, w_x4_2, w_x4_3;
        logic [7:0] w_x8_0, w_x8_1, w_x8_2, w_x8_3;
        logic [7:0] w_m9_0, w_m9_1, w_m9_2, w_m9_3;
        logic [7:0] w_mb_0, w_mb_1, w_mb_2, w_mb_3;
        logic [7:0] w_md_0, w_md_1, w_md_2, w_md_3;
        logic [7:0] w_me_0, w_me_1, w_me_2, w_me_3;
        logic [31:0] w_inv;

        assign w_x4_0 = xtime(w_x2_0);
        assign w_x4_1 = xtime(w_x2_1);
        assign w_x4_2 = xtime(w_x2_2);
        assign w_x4_3 = xtime(w_x2_3);
        assign w_x8_0 = xtime(w_x4_0);
        assign w_x8_1 = xtime(w_x4_1);
        assign w_x8_2 = xtime(w_x4_2);
        assign w_x8_3 = xtime(w_x4_3);

        // 09 = 8+1, 0b = 8+2+1, 0d = 8+4+1, 0e = 8+4+2
        assign w_m9_0 = w_x8_0 ^ w_a0;
        assign w_m9_1 = w_x8_1 ^ w_a1;
        assign w_m9_2 = w_x8_2 ^ w_a2;
        assign w_m9_3 = w_x8_3 ^ w_a3;
        assign w_mb_0 = w_x8_0 ^ w_x2_0 ^ w_a0;
        assign w_mb_1 = w_x8_1 ^ w_x2_1 ^ w_a1;
        assign w_mb_2 = w_x8_2 ^ w_x2_2 ^ w_a2;
        assign w_mb_3 = w_x8_3 ^ w_x2_3 ^ w_a3;
        assign w_md_0 = w_x8_0 ^ w_x4_0 ^ w_a0;
        assign w_md_1 = w_x8_1 ^ w_x4_1 ^ w_a1;
        assign w_md_2 = w_x8_2 ^ w_x4_2 ^ w_a2;
        assign w_md_3 = w_x8_3 ^ w_x4_3 ^ w_a3;
        assign w_me_0 = w_x8_0 ^ w_x4_0 ^ w_x2_0;
        assign w_me_1 = w_x8_1 ^ w_x4_1 ^ w_x2_1;
        assign w_me_2 = w_x8_2 ^ w_x4_2 ^ w_x2_2;
        assign w_me_3 = w_x8_3 ^ w_x4_3 ^ w_x2_3;

        assign w_inv[ 7: 0] = w_me_0 ^ w_mb_1 ^ w_md_2 ^ w_m9_3;
        assign w_inv[15: 8] = w_m9_0 ^ w_me_1 ^ w_mb_2 ^ w_md_3;
        assign w_inv[23:16] = w_md_0 ^ w_m9_1 ^ w_me_2 ^ w_mb_3;
        assign w_inv[31:24] = w_mb_0 ^ w_md_1 ^ w_m9_2 ^ w_me_3;

        assign w_result[32*c +: 32] = inv ? w_inv : w_fwd;
`else
        assign w_result[32*c +: 32] = w_fwd;
`endif
    end

    // Reset wins over in_valid; an idle cycle holds the last result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out <= w_result;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_mix_columns.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mix_columns
//  Description : Self-checking bench for mix_columns. Directed steps drive
//                one input per cycle; expected results are queued when the
//                stimulus is driven and popped when out_valid is seen.
//                Build with +define+INV_MIX_EN to cover the inverse mode.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mix_columns;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic [127:0] in;
    logic         inv;
    logic         out_valid;
    logic [127:0] out;

    int checks;
    int errors;

    logic [127:0] sb_q[$];
    logic [127:0] last_out;

    mix_columns dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in       (in),
`ifdef INV_MIX_EN
        .inv      (inv),
`endif
        .out_valid(out_valid),
        .out      (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Column written as in FIPS-197 text: first byte shown is row 0.
    function automatic logic [31:0] colw(input logic [31:0] c);
        return {c[7:0], c[15:8], c[23:16], c[31:24]};
    endfunction

    function automatic logic [127:0] st(input logic [31:0] c0, input logic [31:0] c1,
                                        input logic [31:0] c2, input logic [31:0] c3);
        return {colw(c3), colw(c2), colw(c1), colw(c0)};
    endfunction

    // Reference GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    // Matrix-based reference model; row r uses coefficients rotated right by r.
    function automatic logic [127:0] model(input logic [127:0] s, input logic do_inv);
        logic [7:0]   k[4];
        logic [127:0] r;
        logic [7:0]   acc;
        if (do_inv) begin
            k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
        end else begin
            k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(s[32*c + 8*j +: 8], k[(j - row + 4) % 4]);
                end
                r[32*c + 8*row +: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus followed by checks of the registered outputs.
    task automatic step(input string tag, input logic v, input logic r,
                        input logic [127:0] data, input logic iv,
                        input logic [127:0] exp);
        logic         exp_v;
        logic [127:0] want;
        @(negedge clk);
        in_valid = v;
        reset    = r;
        in       = data;
        inv      = iv;
        if (v && !r) sb_q.push_back(exp);
        exp_v = v && !r;
        @(posedge clk);
        #1;
        if (r) begin
            sb_q.delete();
            last_out = '0;
        end
        chk({tag, ".valid"}, {127'd0, out_valid}, {127'd0, exp_v});
        if (exp_v) begin
            if (sb_q.size() == 0) begin
                chk({tag, ".sb_empty"}, 128'd1, 128'd0);
            end else begin
                want     = sb_q.pop_front();
                last_out = want;
                chk({tag, ".out"}, out, want);
            end
        end else begin
            chk({tag, ".hold"}, out, last_out);
        end
    endtask

    initial begin
        logic [127:0] fips_in, fips_out, rnd, fwd;
        checks   = 0;
        errors   = 0;
        last_out = '0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in       = '0;
        inv      = 1'b0;

        fips_in  = st(32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5);
        fips_out = st(32'h046681e5, 32'he0cb199a, 32'h48f8d37a, 32'h2806264c);

        step("reset", 1'b0, 1'b1, '0, 1'b0, '0);
        step("fips", 1'b1, 1'b0, fips_in, 1'b0, fips_out);
        step("col_db13", 1'b1, 1'b0, {4{colw(32'hdb135345)}}, 1'b0, {4{colw(32'h8e4da1bc)}});
        step("col_f20a", 1'b1, 1'b0, {4{colw(32'hf20a225c)}}, 1'b0, {4{colw(32'h9fdc589d)}});
        step("col_c6", 1'b1, 1'b0, {4{colw(32'hc6c6c6c6)}}, 1'b0, {4{colw(32'hc6c6c6c6)}});
        step("col_01", 1'b1, 1'b0, {4{colw(32'h01010101)}}, 1'b0, {4{colw(32'h01010101)}});
        step("zero", 1'b1, 1'b0, '0, 1'b0, '0);
        step("idle_after_zero", 1'b0, 1'b0, fips_in, 1'b0, '0);

        // Streaming with model-derived expectations, then a bubble that must hold.
        for (int n = 0; n < 3; n++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            step("stream", 1'b1, 1'b0, rnd, 1'b0, model(rnd, 1'b0));
        end
        step("bubble", 1'b0, 1'b0, {4{32'hdeadbeef}}, 1'b0, '0);
        step("bubble2", 1'b0, 1'b0, {4{32'h12345678}}, 1'b0, '0);

        // Transform in flight, then reset on the next edge.
        step("pre_reset", 1'b1, 1'b0, fips_in, 1'b0, fips_out);
        step("reset_flight", 1'b0, 1'b1, fips_in, 1'b0, '0);
        // Reset and in_valid in the same cycle.
        step("pre_reset2", 1'b1, 1'b0, fips_in, 1'b0, fips_out);
        step("reset_and_valid", 1'b1, 1'b1, fips_in, 1'b0, fips_out);
        step("after_reset", 1'b0, 1'b0, fips_in, 1'b0, '0);

`ifdef INV_MIX_EN
        step("inv_fips", 1'b1, 1'b0, fips_out, 1'b1, fips_in);
        step("inv_col", 1'b1, 1'b0, {4{colw(32'h8e4da1bc)}}, 1'b1, {4{colw(32'hdb135345)}});
        step("fwd_after_inv", 1'b1, 1'b0, fips_in, 1'b0, fips_out);
        for (int n = 0; n < 3; n++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            fwd = model(rnd, 1'b0);
            step("rt_fwd", 1'b1, 1'b0, rnd, 1'b0, fwd);
            step("rt_inv", 1'b1, 1'b0, fwd, 1'b1, rnd);
        end
`endif

        step("final_idle", 1'b0, 1'b0, '0, 1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
